// File: rtl/boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// length field width and checksum seed.
package boot_loader_pkg;

    localparam int          LEN_W     = 16;
    localparam logic [7:0]  CSUM_INIT = 8'h00;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMEM write port of the boot loader.
// master = loader side, slave = byte source / IMEM side.
interface imem_boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/boot_word_packer.sv
// Packs four accepted bytes into a little-endian 32-bit word and emits a
// registered one-cycle word_valid pulse together with the packed word.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [1:0]  byte_cnt_o,
    output logic        word_valid_o,
    output logic [31:0] word_data_o
);
    logic [1:0]  cnt_q;
    logic [23:0] lanes;
    logic        word_valid_q;
    logic [31:0] word_q;
    logic        last_byte;

    assign last_byte = byte_valid_i && (cnt_q == 2'd3) && !clear_i;

    // Lanes 0..2 hold the low bytes; the 4th byte goes straight into the word.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_q;
        always_ff @(posedge clk) begin
            if (rst || clear_i) begin
                lane_q <= 8'h00;
            end else if (byte_valid_i && cnt_q == 2'(gi)) begin
                lane_q <= byte_data_i;
            end
        end
        assign lanes[8*gi +: 8] = lane_q;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= 2'd0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid_q <= 1'b0;
            word_q       <= 32'h0;
        end else begin
            word_valid_q <= last_byte;
            if (last_byte) begin
                word_q <= {byte_data_i, lanes};
            end
        end
    end

    assign byte_cnt_o   = cnt_q;
    assign word_valid_o = word_valid_q;
    assign word_data_o  = word_q;
endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, XOR-checksummed program image as a byte stream,
// writes it word by word into IMEM and holds the CPU in reset until verified.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    imem_boot_loader_if.master bus,
    output logic               cpu_rst,
    output logic               done,
    output logic               error
);
    localparam int               IDX_W   = $clog2(MAX_WORDS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_t             state_q, state_d;
    logic               ready_q;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [31:0]        addr_q, addr_d;
    logic               accept;
    logic               pk_valid;
    logic [1:0]         pk_cnt;
    logic [LEN_W-1:0]   len_full;

    assign accept   = bus.in_valid && ready_q;
    assign pk_valid = accept && (state_q == DATA);
    assign len_full = {bus.in_data, len_q[7:0]};

    boot_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (state_q != DATA),
        .byte_valid_i (pk_valid),
        .byte_data_i  (bus.in_data),
        .byte_cnt_o   (pk_cnt),
        .word_valid_o (bus.imem_we),
        .word_data_o  (bus.imem_wdata)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        case (state_q)
            LEN0: if (accept) begin
                len_d[7:0] = bus.in_data;
                state_d    = LEN1;
            end
            LEN1: if (accept) begin
                len_d = len_full;
                if (len_full == '0)          state_d = CSUM;
                else if (len_full > MAX_LEN) state_d = ERR;
                else                         state_d = DATA;
            end
            DATA: if (accept) begin
                csum_d = csum_q ^ bus.in_data;
                // Address is latched with the 4th byte so it lines up with the write strobe.
                if (pk_cnt == 2'd3) begin
                    idx_d  = idx_q + 1'b1;
                    addr_d = BASE_ADDR + (32'(idx_q) << 2);
                    if (LEN_W'(idx_q) + LEN_W'(1) == len_q) state_d = CSUM;
                end
            end
            CSUM: if (accept) begin
                state_d = (bus.in_data == csum_q) ? DONE : ERR;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEN0;
            ready_q <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= CSUM_INIT;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != DONE) && (state_d != ERR);
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.imem_addr = addr_q;
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERR);
    // Already merged with the pipeline reset, so the CPU can use it directly.
    assign cpu_rst       = rst || (state_q != DONE);
endmodule
